// File: rtl/noc_router_xy_if.sv
// Link bundle for the 5-port XY mesh router.
// Ports packed 0=Local, 1=N, 2=E, 3=S, 4=W.
interface noc_router_xy_if #(
  parameter int FLIT_W = 36
);
  logic [4:0]          in_valid;
  logic [5*FLIT_W-1:0] in_data;
  logic [4:0]          in_ready;
  logic [4:0]          out_valid;
  logic [5*FLIT_W-1:0] out_data;
  logic [4:0]          out_ready;
  logic                route_err;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  route_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output route_err
  );
endinterface

// File: rtl/noc_router_xy.sv
// 5-port XY mesh router: input FIFOs, RR arbiters, registered outputs.
// NOC_ROUTER_STATS_EN adds saturating per-output flit counters.
module noc_router_xy #(
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 4,
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int COORD_W    = 2,
  parameter int PAYLOAD_W  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
`ifdef NOC_ROUTER_STATS_EN
  output logic [5*16-1:0] flit_cnt,
`endif
  noc_router_xy_if.slave  link
);
  localparam int FLIT_W = 2*COORD_W + PAYLOAD_W;
  localparam int NP = 5;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_V = FIFO_DEPTH[AW:0];

  logic [FLIT_W-1:0]  mem [NP][FIFO_DEPTH];
  logic [AW:0]        wr_ptr [NP];
  logic [AW:0]        rd_ptr [NP];
  logic [NP-1:0]      full;
  logic [NP-1:0]      empty;
  logic [NP-1:0]      push;
  logic [NP-1:0]      pop;
  logic [FLIT_W-1:0]  head [NP];
  logic [COORD_W-1:0] dx [NP];
  logic [COORD_W-1:0] dy [NP];
  logic [NP-1:0]      oom;
  logic [NP-1:0]      req [NP];
  logic [NP-1:0]      gnt [NP];
  logic [2:0]         sel [NP];
  logic [NP-1:0]      load;
  logic [NP-1:0]      can;
  logic [2:0]         rr_ptr [NP];
  logic [NP-1:0]      vld_q;
  logic [FLIT_W-1:0]  out_q [NP];
  logic               err_q;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      full[p]  = (wr_ptr[p] - rd_ptr[p]) == DEPTH_V;
      empty[p] = wr_ptr[p] == rd_ptr[p];
      push[p]  = link.in_valid[p] && !full[p];
      head[p]  = mem[p][rd_ptr[p][AW-1:0]];
    end
  end

  // req[p] is a one-hot output select for input p's head flit
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      dx[p]  = head[p][FLIT_W-1 -: COORD_W];
      dy[p]  = head[p][PAYLOAD_W +: COORD_W];
      oom[p] = int'(dx[p]) >= MESH_X ||
               int'(dy[p]) >= MESH_Y;
      req[p] = '0;
      if (!empty[p]) begin
        if (oom[p])
          req[p][0] = 1'b1;
        else if (int'(dx[p]) > X_COORD)
          req[p][2] = 1'b1;
        else if (int'(dx[p]) < X_COORD)
          req[p][4] = 1'b1;
        else if (int'(dy[p]) > Y_COORD)
          req[p][1] = 1'b1;
        else if (int'(dy[p]) < Y_COORD)
          req[p][3] = 1'b1;
        else
          req[p][0] = 1'b1;
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NP; o++) begin
      can[o]  = !vld_q[o] || link.out_ready[o];
      gnt[o]  = '0;
      sel[o]  = '0;
      load[o] = 1'b0;
      for (int i = 0; i < NP; i++) begin
        idx = int'(rr_ptr[o]) + i;
        if (idx >= NP)
          idx = idx - NP;
        if (!load[o] && can[o] && req[idx][o]) begin
          gnt[o][idx] = 1'b1;
          sel[o]      = 3'(idx);
          load[o]     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < NP; o++)
      pop = pop | gnt[o];
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (push[p])
        mem[p][wr_ptr[p][AW-1:0]] <=
          link.in_data[p*FLIT_W +: FLIT_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        rr_ptr[i] <= '0;
        out_q[i]  <= '0;
      end
      vld_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (push[p])
          wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])
          rd_ptr[p] <= rd_ptr[p] + 1'b1;
      end
      for (int o = 0; o < NP; o++) begin
        if (load[o]) begin
          out_q[o]  <= head[sel[o]];
          vld_q[o]  <= 1'b1;
          rr_ptr[o] <= (sel[o] == 3'd4) ?
                       3'd0 : sel[o] + 3'd1;
        end else if (link.out_ready[o]) begin
          vld_q[o] <= 1'b0;
        end
      end
      if (|(pop & oom))
        err_q <= 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++)
      link.out_data[o*FLIT_W +: FLIT_W] = out_q[o];
  end

  assign link.in_ready  = ~full;
  assign link.out_valid = vld_q;
  assign link.route_err = err_q;

`ifdef NOC_ROUTER_STATS_EN
  logic [15:0] cnt [NP];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NP; o++)
        cnt[o] <= '0;
    end else begin
      for (int o = 0; o < NP; o++)
        if (vld_q[o] && link.out_ready[o] &&
            cnt[o] != 16'hFFFF)
          cnt[o] <= cnt[o] + 16'd1;
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++)
      flit_cnt[o*16 +: 16] = cnt[o];
  end
`endif
endmodule

// File: tb/tb_noc_router_xy.sv
// Directed scoreboard bench for noc_router_xy at (1,1) in a 4x4 mesh.
// COORD_W=3 so out-of-mesh destinations can be expressed.
module tb_noc_router_xy;
  localparam int CW = 3;
  localparam int PW = 32;
  localparam int FW = 2*CW + PW;
  localparam int NP = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_router_xy_if #(.FLIT_W(FW)) link ();
`ifdef NOC_ROUTER_STATS_EN
  logic [5*16-1:0] flit_cnt;
`endif

  noc_router_xy #(
    .MESH_X(4), .MESH_Y(4),
    .X_COORD(1), .Y_COORD(1),
    .COORD_W(CW), .PAYLOAD_W(PW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef NOC_ROUTER_STATS_EN
    .flit_cnt(flit_cnt),
`endif
    .link(link)
  );

  int total = 0;
  int bad = 0;
  logic [FW-1:0] expq [NP*NP][$];
  int elog [$];

  function automatic logic [FW-1:0] mk(
    int x, int y, logic [31:0] pl);
    logic [CW-1:0] cx, cy;
    cx = CW'(x);
    cy = CW'(y);
    return {cx, cy, pl};
  endfunction

  function automatic int route(logic [FW-1:0] f);
    int x, y;
    x = int'(f[FW-1 -: CW]);
    y = int'(f[PW +: CW]);
    if (x >= 4 || y >= 4) return 0;
    if (x > 1) return 2;
    if (x < 1) return 4;
    if (y > 1) return 1;
    if (y < 1) return 3;
    return 0;
  endfunction

  function automatic int qtotal();
    int n;
    n = 0;
    for (int i = 0; i < NP*NP; i++)
      n += expq[i].size();
    return n;
  endfunction

  task automatic chk(string tag,
    logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Score transfers/acceptances happening at the next edge, then advance.
  task automatic step();
    logic [4:0] acc, xfer;
    logic [FW-1:0] f;
    logic found;
    acc  = link.in_valid & link.in_ready;
    xfer = link.out_valid & link.out_ready;
    for (int o = 0; o < NP; o++) begin
      if (xfer[o] === 1'b1) begin
        f = link.out_data[o*FW +: FW];
        found = 1'b0;
        for (int s = 0; s < NP; s++) begin
          if (!found && expq[s*NP+o].size() > 0 &&
              expq[s*NP+o][0] === f) begin
            void'(expq[s*NP+o].pop_front());
            found = 1'b1;
            if (o == 2) elog.push_back(s);
          end
        end
        total++;
        assert (found) else begin
          bad++;
          $error("FAIL xfer_out%0d observed=%0h expected=queued",
                 o, f);
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (acc[p] === 1'b1) begin
        f = link.in_data[p*FW +: FW];
        expq[p*NP+route(f)].push_back(f);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    link.in_valid = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < NP*NP; i++)
      expq[i].delete();
    elog.delete();
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++)
      step();
  endtask

  initial begin
    logic [FW-1:0] f;
    int seq [3];
    seq[0] = 0;
    seq[1] = 1;
    seq[2] = 3;
    rst = 1'b1;
    link.in_valid  = '0;
    link.in_data   = '0;
    link.out_ready = 5'h1F;
    step();
    step();
    chk("rst_out_valid", 64'(link.out_valid), 64'h0);
    chk("rst_in_ready", 64'(link.in_ready), 64'h1F);
    chk("rst_out_data", 64'(|link.out_data), 64'h0);
    chk("rst_route_err", 64'(link.route_err), 64'h0);
    rst = 1'b0;

    // Local -> E, one-cycle latency
    f = mk(3, 1, 32'hDEADBEEF);
    link.in_data[0*FW +: FW] = f;
    link.in_valid = 5'b00001;
    step();
    link.in_valid = '0;
    chk("lat_early", 64'(link.out_valid), 64'h0);
    step();
    chk("e_valid", 64'(link.out_valid), 64'h04);
    chk("e_data", 64'(link.out_data[2*FW +: FW]), 64'(f));
    drain(2);
    chk("e_idle", 64'(link.out_valid), 64'h0);
`ifdef NOC_ROUTER_STATS_EN
    chk("cnt_e", 64'(flit_cnt[2*16 +: 16]), 64'd1);
`endif

    // W -> N and N -> Local in the same cycle
    link.in_data[4*FW +: FW] = mk(1, 3, 32'h1111_0004);
    link.in_data[1*FW +: FW] = mk(1, 1, 32'h2222_0001);
    link.in_valid = 5'b10010;
    step();
    link.in_valid = '0;
    step();
    chk("nl_valid", 64'(link.out_valid), 64'h03);
    chk("n_data", 64'(link.out_data[1*FW +: FW]),
        64'(mk(1, 3, 32'h1111_0004)));
    chk("l_data", 64'(link.out_data[0*FW +: FW]),
        64'(mk(1, 1, 32'h2222_0001)));
    drain(2);
    chk("nl_drained", 64'(qtotal()), 64'd0);

    // Three inputs contend for E
    do_reset();
    link.in_valid = 5'b01011;
    for (int i = 0; i < 16; i++) begin
      for (int p = 0; p < NP; p++)
        link.in_data[p*FW +: FW] =
          mk(3, 1, {16'(p), 16'(i)});
      step();
      if (i >= 1)
        chk($sformatf("rr_thru_%0d", i),
            64'(link.out_valid), 64'h04);
    end
    link.in_valid = '0;
    drain(20);
    chk("rr_drained", 64'(qtotal()), 64'd0);
    chk("rr_enough", 64'(elog.size() >= 9), 64'd1);
    for (int k = 0; k < 9; k++)
      chk($sformatf("rr_order_%0d", k),
          64'((k < elog.size()) ? elog[k] : -1),
          64'(seq[k % 3]));

    // Backpressure on E: 1 in register + 4 in FIFO
    link.out_ready = 5'b11011;
    for (int i = 0; i < 5; i++) begin
      link.in_data[0*FW +: FW] = mk(3, 1, 32'(100 + i));
      link.in_valid = 5'b00001;
      chk($sformatf("bp_ready_%0d", i),
          64'(link.in_ready[0]), 64'd1);
      step();
    end
    link.in_valid = '0;
    chk("bp_full", 64'(link.in_ready[0]), 64'd0);
    chk("bp_valid", 64'(link.out_valid), 64'h04);
    drain(2);
    chk("bp_hold", 64'(link.out_data[2*FW +: FW]),
        64'(mk(3, 1, 32'd100)));
    link.out_ready = 5'h1F;
    drain(7);
    chk("bp_drained", 64'(qtotal()), 64'd0);

    // Out-of-mesh destination goes Local and sets route_err
    chk("err_clear", 64'(link.route_err), 64'd0);
    link.in_data[2*FW +: FW] = mk(5, 0, 32'hBAD0_0005);
    link.in_valid = 5'b00100;
    step();
    link.in_valid = '0;
    step();
    chk("oom_local", 64'(link.out_valid), 64'h01);
    chk("oom_err", 64'(link.route_err), 64'd1);
    link.in_data[0*FW +: FW] = mk(0, 1, 32'h0000_0777);
    link.in_valid = 5'b00001;
    step();
    link.in_valid = '0;
    drain(3);
    chk("err_sticky", 64'(link.route_err), 64'd1);
    chk("oom_drained", 64'(qtotal()), 64'd0);

    // Reset with traffic in FIFOs and output registers
    link.out_ready = '0;
    for (int p = 0; p < NP; p++)
      link.in_data[p*FW +: FW] = mk(p % 4, 3, 32'(p));
    link.in_valid = 5'h1F;
    drain(3);
    chk("pre_rst_busy", 64'(|link.out_valid), 64'd1);
    do_reset();
    link.out_ready = 5'h1F;
    chk("mid_rst_valid", 64'(link.out_valid), 64'h0);
    chk("mid_rst_ready", 64'(link.in_ready), 64'h1F);
    chk("mid_rst_err", 64'(link.route_err), 64'd0);
`ifdef NOC_ROUTER_STATS_EN
    chk("mid_rst_cnt", 64'(|flit_cnt), 64'd0);
`endif
    drain(2);
    chk("post_rst_idle", 64'(link.out_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
